// File: rtl/pixel_frame_writer_pkg.sv
// Shared types and constants for the pixel frame writer.
package pixel_frame_writer_pkg;

    localparam int unsigned PIX_PER_WORD = 4;
    localparam int unsigned WORD_DATA_W  = 8 * PIX_PER_WORD;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DRAIN
    } state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; a pop in the same cycle frees a slot for a push when full.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    // Accepted push/pop strobes; a full FIFO still takes a push alongside a pop.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem[rptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/pixel_frame_writer.sv
// Captures one raster frame, packs 4 pixels per word and writes it to a
// word-addressed frame buffer through a valid/ready write port.
module pixel_frame_writer
    import pixel_frame_writer_pkg::*;
#(
    parameter int unsigned          WIDTH      = 640,
    parameter int unsigned          HEIGHT     = 480,
    parameter int unsigned          ADDR_W     = 17,
    parameter logic [ADDR_W-1:0]    BASE_ADDR  = '0,
    parameter int unsigned          FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [7:0]        data_i,
    input  logic              start_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o
);

    localparam int unsigned XW = cnt_w(WIDTH);
    localparam int unsigned YW = cnt_w(HEIGHT);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // Each FIFO entry carries its own address so dropped words never shift later ones.
    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [WORD_DATA_W-1:0] data;
    } word_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       pack_q, pack_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              ovf_q, ovf_d;

    logic              at_origin;
    logic              at_last;
    logic              take;
    logic [1:0]        lane_base;
    logic [ADDR_W-1:0] waddr_base;

    logic              fifo_push;
    logic              fifo_pop;
    word_t             push_word;
    word_t             head_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign at_origin = (x_q == '0) && (y_q == '0);
    assign at_last   = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));
    assign fifo_pop  = !fifo_empty && wr_ready_i;

    // Raster position advances on every pixel regardless of capture state.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (valid_i) begin
            if (x_q == XW'(WIDTH - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Capture sequencing: arm, align to frame origin, pack, drain the FIFO.
    always_comb begin
        state_d    = state_q;
        take       = 1'b0;
        lane_base  = lane_q;
        waddr_base = waddr_q;
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = ARMED;
            end
            ARMED: begin
                // The origin pixel restarts lane and address in the same cycle it is packed.
                if (valid_i && at_origin) begin
                    take       = 1'b1;
                    lane_base  = '0;
                    waddr_base = BASE_ADDR;
                    state_d    = CAPTURE;
                end
            end
            CAPTURE: begin
                if (valid_i) begin
                    take = 1'b1;
                    if (at_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // No pushes occur here, so popping the sole entry empties the FIFO.
                if (fifo_empty || (fifo_pop && fifo_count == CW'(1))) begin
                    state_d = IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane packing, word addressing and overflow detection.
    always_comb begin
        lane_d         = lane_q;
        pack_d         = pack_q;
        waddr_d        = waddr_base;
        fifo_push      = 1'b0;
        push_word.addr = waddr_base;
        push_word.data = {data_i, pack_q};
        if (take) begin
            lane_d = lane_base + 2'd1;
            case (lane_base)
                2'd0: pack_d[7:0]   = data_i;
                2'd1: pack_d[15:8]  = data_i;
                2'd2: pack_d[23:16] = data_i;
                default: begin
                    fifo_push = 1'b1;
                    waddr_d   = waddr_base + ADDR_W'(1);
                end
            endcase
        end
        ovf_d = ovf_q || (fifo_push && fifo_full && !fifo_pop);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Raster, packing and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            lane_q  <= '0;
            pack_q  <= '0;
            waddr_q <= BASE_ADDR;
            ovf_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            waddr_q <= waddr_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .DATA_W ($bits(word_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (push_word),
        .pop_i   (fifo_pop),
        .rdata_o (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign wr_valid_o = !fifo_empty;
    assign wr_addr_o  = fifo_empty ? BASE_ADDR : head_word.addr;
    assign wr_data_o  = fifo_empty ? '0 : head_word.data;
    assign busy_o     = (state_q != IDLE);
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer on an 8x2 frame (4 words).
module tb_pixel_frame_writer;

    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [7:0]    data_i;
    logic          start_i;
    logic          wr_valid_o;
    logic          wr_ready_i;
    logic [AW-1:0] wr_addr_o;
    logic [31:0]   wr_data_o;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned done_cnt = 0;
    int unsigned stall_err = 0;
    int unsigned base;

    logic [AW+31:0] wq[$];
    logic           stall_q = 1'b0;
    logic [AW-1:0]  stall_addr;
    logic [31:0]    stall_data;

    pixel_frame_writer #(
        .WIDTH      (8),
        .HEIGHT     (2),
        .ADDR_W     (AW),
        .BASE_ADDR  (17'd0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .start_i    (start_i),
        .wr_valid_o (wr_valid_o),
        .wr_ready_i (wr_ready_i),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    // Write-port monitor: logs accepted words, counts done pulses, checks hold-while-stalled.
    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && !(wr_valid_o && wr_addr_o == stall_addr && wr_data_o == stall_data))
                stall_err++;
            if (wr_valid_o && wr_ready_i) wq.push_back({wr_addr_o, wr_data_o});
            stall_q    = wr_valid_o && !wr_ready_i;
            stall_addr = wr_addr_o;
            stall_data = wr_data_o;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [7:0] v);
        valid_i = 1'b1;
        data_i  = v;
        step();
        valid_i = 1'b0;
    endtask

    task automatic pixels(input logic [7:0] first, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) pix(first + 8'(i));
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wr_valid"}, 64'(wr_valid_o), 64'd0);
        chk({tag, "_wr_addr"},  64'(wr_addr_o),  64'd0);
        chk({tag, "_wr_data"},  64'(wr_data_o),  64'd0);
        chk({tag, "_busy"},     64'(busy_o),     64'd0);
        chk({tag, "_done"},     64'(done_o),     64'd0);
        chk({tag, "_overflow"}, 64'(overflow_o), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int unsigned b);
        for (int unsigned i = 0; i < 200 && done_cnt == b; i++) step();
        repeat (3) step();
        chk({tag, "_done_pulses"}, 64'(done_cnt - b), 64'd1);
        chk({tag, "_busy_after"},  64'(busy_o), 64'd0);
    endtask

    // Expected word k holds pixels first+4k .. first+4k+3, low byte first, at address k.
    task automatic check_frame(input string tag, input logic [7:0] first, input int unsigned nw);
        logic [7:0]     b;
        logic [AW+31:0] e;
        logic [AW+31:0] o;
        chk({tag, "_nwords"}, 64'(wq.size()), 64'(nw));
        for (int unsigned k = 0; k < nw; k++) begin
            b = first + 8'(4 * k);
            e = {AW'(k), b + 8'd3, b + 8'd2, b + 8'd1, b};
            o = (k < wq.size()) ? wq[k] : 'x;
            chk($sformatf("%s_word%0d", tag, k), 64'(o), 64'(e));
        end
        wq.delete();
    endtask

    initial begin
        rst        = 1'b1;
        valid_i    = 1'b0;
        data_i     = '0;
        start_i    = 1'b0;
        wr_ready_i = 1'b1;
        step();
        step();
        check_reset("reset");
        rst = 1'b0;

        // Basic contiguous capture.
        base = done_cnt;
        pulse_start();
        chk("basic_armed_busy", 64'(busy_o), 64'd1);
        pixels(8'h01, 4);
        chk("basic_latency_valid", 64'(wr_valid_o), 64'd1);
        chk("basic_latency_addr",  64'(wr_addr_o),  64'd0);
        chk("basic_latency_data",  64'(wr_data_o),  64'h04030201);
        pixels(8'h05, 12);
        wait_done("basic", base);
        check_frame("basic", 8'h01, 4);

        // Start mid-frame: capture waits for the next origin.
        base = done_cnt;
        pixels(8'hA0, 5);
        pulse_start();
        pixels(8'hB0, 11);
        chk("align_waiting_busy",   64'(busy_o), 64'd1);
        chk("align_nothing_yet",    64'(wq.size()), 64'd0);
        chk("align_no_valid",       64'(wr_valid_o), 64'd0);
        pixels(8'h11, 16);
        wait_done("align", base);
        check_frame("align", 8'h11, 4);

        // Start coinciding with an origin pixel in IDLE defers to the following frame.
        base = done_cnt;
        start_i = 1'b1;
        pix(8'hC0);
        start_i = 1'b0;
        pixels(8'hC1, 15);
        chk("coinc_waiting_busy", 64'(busy_o), 64'd1);
        chk("coinc_nothing_yet",  64'(wq.size()), 64'd0);
        pixels(8'h81, 16);
        wait_done("coinc", base);
        check_frame("coinc", 8'h81, 4);

        // Backpressure: one pixel per 4 cycles, ready low for 10 cycles while word 1 waits.
        base = done_cnt;
        pulse_start();
        for (int unsigned c = 0; c < 64; c++) begin
            valid_i    = (c % 4 == 0);
            data_i     = 8'h31 + 8'(c / 4);
            wr_ready_i = !(c >= 26 && c < 36);
            step();
            if (c == 32) begin
                chk("bp_hold_valid", 64'(wr_valid_o), 64'd1);
                chk("bp_hold_addr",  64'(wr_addr_o),  64'd1);
                chk("bp_hold_data",  64'(wr_data_o),  64'h38373635);
            end
        end
        valid_i    = 1'b0;
        wr_ready_i = 1'b1;
        wait_done("bp", base);
        check_frame("bp", 8'h31, 4);
        chk("bp_overflow", 64'(overflow_o), 64'd0);
        chk("bp_stability", 64'(stall_err), 64'd0);

        // Blanking gaps: 8 pixels on, 2 cycles off.
        base = done_cnt;
        pulse_start();
        for (int unsigned p = 0; p < 16; p++) begin
            pix(8'h01 + 8'(p));
            if (p % 8 == 7) begin
                step();
                step();
            end
        end
        wait_done("blank", base);
        check_frame("blank", 8'h01, 4);

        // Overflow: no ready during capture, FIFO of 2 keeps words 0 and 1 only.
        base = done_cnt;
        wr_ready_i = 1'b0;
        pulse_start();
        pixels(8'h41, 16);
        chk("ovf_flag",       64'(overflow_o), 64'd1);
        chk("ovf_head_valid", 64'(wr_valid_o), 64'd1);
        chk("ovf_head_addr",  64'(wr_addr_o),  64'd0);
        chk("ovf_head_data",  64'(wr_data_o),  64'h44434241);
        chk("ovf_drain_busy", 64'(busy_o),     64'd1);
        repeat (5) step();
        chk("ovf_no_early_done", 64'(done_cnt - base), 64'd0);
        wr_ready_i = 1'b1;
        wait_done("ovf", base);
        check_frame("ovf", 8'h41, 2);
        chk("ovf_sticky", 64'(overflow_o), 64'd1);

        // Reset in the middle of a capture.
        base = done_cnt;
        pulse_start();
        pixels(8'h61, 8);
        step();
        step();
        check_frame("pre_rst", 8'h61, 2);
        rst = 1'b1;
        step();
        step();
        check_reset("midrst");
        rst = 1'b0;
        step();
        step();
        chk("midrst_no_done", 64'(done_cnt - base), 64'd0);
        chk("midrst_no_writes", 64'(wq.size()), 64'd0);
        base = done_cnt;
        pulse_start();
        pixels(8'h71, 16);
        wait_done("post_rst", base);
        check_frame("post_rst", 8'h71, 4);
        chk("final_stability", 64'(stall_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_frame_writer.md
Name: pixel_frame_writer

Overview:
- Sink at the output end of the pixel pipeline (gray -> gauss -> sobel), consuming the same valid_i/data_i raster stream that the pipeline produces.
- Tracks raster position, packs 8-bit pixels 4-per-word and writes one complete frame to a word-addressed frame buffer over a valid/ready write port.
- Single-shot capture: armed by start_i, begins at the next frame origin, signals completion with done_o.

Parameters:
- WIDTH, 640, active pixels per line; must be a multiple of 4.
- HEIGHT, 480, lines per frame.
- ADDR_W, 17, word address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT/4.
- BASE_ADDR, 0, word address of pixel (0,0).
- FIFO_DEPTH, 4, packed-word buffer entries; power of 2, >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  pixel strobe; no backpressure; gaps (blanking) are allowed anywhere.
- data_i  in  8  pixel value, sampled when valid_i=1.
- start_i  in  1  one-cycle request to capture the next frame.
- wr_valid_o  out  1  write request.
- wr_ready_i  in  1  write accept; a transfer completes when wr_valid_o & wr_ready_i.
- wr_addr_o  out  ADDR_W  word address.
- wr_data_o  out  32  packed pixels; first pixel of the group in [7:0], fourth in [31:24].
- busy_o  out  1  high in ARMED, CAPTURE and DRAIN.
- done_o  out  1  one-cycle pulse when the last frame word is accepted.
- overflow_o  out  1  sticky error: a packed word was dropped because the FIFO was full.

Behaviour:
- Reset values: wr_valid_o=0, wr_addr_o=BASE_ADDR, wr_data_o=0, busy_o=0, done_o=0, overflow_o=0. Pack register and FIFO are emptied, x=y=0, state=IDLE.
- Raster counters:
  - x and y run from reset in every state.
  - On each valid_i, x increments; at WIDTH-1 x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1) both wrap to 0.
  - The first pixel after reset is (0,0).
- State machine:
  - IDLE: start_i -> ARMED. Pixels are discarded.
  - ARMED: a valid_i pixel at x=0,y=0 is captured and the state moves to CAPTURE in that same cycle. If start_i and a (0,0) pixel coincide in IDLE, capture starts at the following frame's (0,0).
  - CAPTURE: every valid_i pixel is packed. After pixel (WIDTH-1, HEIGHT-1) is packed -> DRAIN.
  - DRAIN: pixels are ignored; once the FIFO is empty and the final word has been accepted -> IDLE with done_o=1 for exactly that cycle.
  - start_i outside IDLE is ignored.
- Packing:
  - A 2-bit lane counter places pixels into bytes 0..3 in order.
  - Every 4th pixel, the completed word enters the FIFO in the same cycle (the word is visible at the FIFO head 1 cycle later).
  - The lane counter resets at the start of each capture.
- FIFO:
  - Standard synchronous FIFO. Simultaneous push and pop while full is allowed: the pop frees the slot for the push.
  - Push while full (no pop that cycle): the word is dropped, overflow_o sets and stays set until rst. Capture continues and addressing still advances, so later words land at correct addresses.
- Write port:
  - wr_valid_o = FIFO not empty; wr_data_o = FIFO head.
  - wr_valid_o, wr_addr_o and wr_data_o stay stable while wr_valid_o=1 and wr_ready_i=0.
  - wr_addr_o starts at BASE_ADDR for each capture and increments by 1 per accepted word, with modulo 2**ADDR_W wrap.
  - The address is carried with each FIFO entry, so dropped words never shift later addresses.
- Latency: last pixel of a group -> wr_valid_o high = 1 cycle when the FIFO was empty.
- Reset mid-operation: everything returns to reset values; pending words are lost; no done_o.
- Arithmetic: x is clog2(WIDTH) bits and y is clog2(HEIGHT) bits, both unsigned. Word count per frame = WIDTH*HEIGHT/4.

Decomposition:
- Package pixel_frame_writer_pkg:
  - state enum {IDLE, ARMED, CAPTURE, DRAIN}.
  - Word type: 32-bit data plus ADDR_W address.
  - Constant PIX_PER_WORD=4.
- One sub-module, sync_fifo (parameterised width and depth; outputs full and empty), holding {addr, data} entries.

Test Plan:
- Use WIDTH=8, HEIGHT=2 (4 words) for all scenarios.
- Basic capture: reset; start_i; 16 contiguous pixels of value 1..16 with wr_ready_i=1 -> words 0x04030201@0, 0x08070605@1, 0x0C0B0A09@2, 0x100F0E0D@3; done_o pulses once.
- Alignment: start_i issued after 5 pixels of a frame -> nothing written until the next frame's (0,0); that frame's first word is written at BASE_ADDR.
- Backpressure: wr_ready_i low for 10 cycles during capture, with 1 valid per 4 cycles -> addr/data held stable, all 4 words delivered in order, overflow_o=0.
- Overflow: wr_ready_i=0 throughout, 16 contiguous pixels, FIFO_DEPTH=2 -> 2 words queued, overflow_o=1. After releasing ready: words at addresses 0 and 1 are written, done_o still pulses.
- Blanking gaps: valid_i pattern of 8 on / 2 off -> same output as the basic capture test.
- Reset mid-capture: rst asserted after 2 words -> outputs return to reset values, no done_o. A new start_i then captures correctly from address 0.
